// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with bounded tenure under contention and a
// mandatory one-cycle turnaround (all grants released) between consecutive grants.
module bus_arbiter #(
    parameter int MAXT = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] req,
    output logic [3:0] grt,
    output logic       busy,
    output logic [1:0] owner
);

    localparam int TW = $clog2(MAXT);
    localparam logic [TW-1:0] TMAX = TW'(MAXT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t        state, state_n;
    logic [3:0]    grt_n;
    logic [1:0]    owner_n;
    logic [1:0]    rr, rr_n;
    logic [TW-1:0] tenure, tenure_n;
    logic [1:0]    win;
    logic          release_now;

    // First requester at or after pointer p; scanning high offsets first lets the
    // lowest offset overwrite the selection last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] sel;
        sel = p;
        for (int k = 3; k >= 0; k--) begin
            if (r[p + 2'(k)]) sel = p + 2'(k);
        end
        return sel;
    endfunction

    assign win  = pick(req, rr);
    assign busy = |grt;

    // grt is one-hot on owner while in GRANT, so req & ~grt is exactly "someone else waits".
    assign release_now = !req[owner] || (tenure == TMAX && (req & ~grt) != 4'b0000);

    // NOTE: every output of this block gets a default first so no path leaves one
    // unassigned; that is what keeps the combinational process from inferring latches.
    always_comb begin
        state_n  = state;
        grt_n    = grt;
        owner_n  = owner;
        rr_n     = rr;
        tenure_n = tenure;
        case (state)
            IDLE, TURN: begin
                if (req != 4'b0000) begin
                    state_n  = GRANT;
                    grt_n    = 4'b0001 << win;
                    owner_n  = win;
                    tenure_n = '0;
                end else begin
                    state_n = IDLE;
                    grt_n   = 4'b0000;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_n = TURN;
                    grt_n   = 4'b0000;
                    rr_n    = owner + 2'd1;
                end else if (tenure != TMAX) begin
                    tenure_n = tenure + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grt_n   = 4'b0000;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            grt    <= 4'b0000;
            owner  <= 2'd0;
            rr     <= 2'd0;
            tenure <= '0;
        end else begin
            state  <= state_n;
            grt    <= grt_n;
            owner  <= owner_n;
            rr     <= rr_n;
            tenure <= tenure_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle-level reference model of the arbitration
// rules is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_bus_arbiter;

    localparam int MAXT = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grt;
    logic       busy;
    logic [1:0] owner;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    bus_arbiter #(.MAXT(MAXT)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .req  (req),
        .grt  (grt),
        .busy (busy),
        .owner(owner)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_own is the master holding the bus (-1 when none), m_held
    // counts cycles it has held it, m_ptr is where the next search starts.
    int m_own  = -1;
    int m_last = 0;
    int m_ptr  = 0;
    int m_held = 0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_own  = -1;
            m_last = 0;
            m_ptr  = 0;
            m_held = 0;
        end else if (m_own < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_own < 0 && req[(m_ptr + k) % 4]) m_own = (m_ptr + k) % 4;
            end
            if (m_own >= 0) begin
                m_last = m_own;
                m_held = 1;
            end
        end else if (!req[m_own] || (m_held >= MAXT && (req & ~(4'b0001 << m_own)) != 4'b0000)) begin
            m_ptr = (m_own + 1) % 4;
            m_own = -1;
        end else begin
            m_held++;
        end
    end

    function automatic logic [3:0] model_grt();
        return (m_own < 0) ? 4'b0000 : 4'(4'b0001 << m_own);
    endfunction

    always @(negedge Clk) begin
        if (run) begin
            check("grt_vs_model", 32'(grt), 32'(model_grt()));
            check("busy_vs_model", 32'(busy), 32'(model_grt() != 4'b0000));
            check("owner_vs_model", 32'(owner), 32'(m_last));
            check("grt_onehot0", 32'($onehot0(grt)), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    int held;

    initial begin
        #1 run = 1'b1;
        tick(2);
        check("reset_grt", 32'(grt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_owner", 32'(owner), 32'h0);
        Rst = 1'b0;

        // single master held for five sampled edges
        req = 4'b0001;
        tick(1); check("single_first", 32'(grt), 32'h1);
        tick(4); check("single_fifth", 32'(grt), 32'h1);
        req = 4'b0000;
        tick(1); check("single_release", 32'(grt), 32'h0);
        check("single_owner", 32'(owner), 32'h0);
        tick(2);

        // re-grant to the same master still passes through one idle cycle
        req = 4'b0001;
        tick(1); check("regrant_a", 32'(grt), 32'h1);
        req = 4'b0000;
        tick(1); check("regrant_gap", 32'(grt), 32'h0);
        req = 4'b0001;
        tick(1); check("regrant_b", 32'(grt), 32'h1);
        req = 4'b0000;
        tick(2);

        // all four requesting: rotation with MAXT-cycle tenure
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        req = 4'b1111;
        tick(1); check("rot_m0_start", 32'(grt), 32'h1);
        tick(3); check("rot_m0_last", 32'(grt), 32'h1);
        tick(1); check("rot_gap", 32'(grt), 32'h0);
        tick(1); check("rot_m1_start", 32'(grt), 32'h2);
        tick(15); check("rot_m0_again", 32'(grt), 32'h1);
        req = 4'b0000;
        tick(2);

        // pointer wrap: after master 2 releases, 0 beats 2
        req = 4'b0100;
        tick(1); check("rr_m2", 32'(grt), 32'h4);
        req = 4'b0000;
        tick(2);
        req = 4'b0101;
        tick(1); check("rr_wrap_m0", 32'(grt), 32'h1);
        req = 4'b0100;
        tick(1); check("rr_m0_release", 32'(grt), 32'h0);
        tick(1); check("rr_then_m2", 32'(grt), 32'h4);
        req = 4'b0000;
        tick(2);

        // lone requester keeps the bus; a newcomer preempts a saturated tenure at once
        req = 4'b0100;
        tick(1);
        held = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (grt == 4'b0100) held++;
        end
        check("alone_40_cycles", 32'(held), 32'd40);
        req = 4'b0110;
        tick(1); check("sat_preempt", 32'(grt), 32'h0);
        tick(1); check("sat_next_m1", 32'(grt), 32'h2);
        req = 4'b0000;
        tick(2);

        // asynchronous reset in the middle of a grant
        req = 4'b1000;
        tick(1); check("pre_reset_m3", 32'(grt), 32'h8);
        tick(2);
        #1 Rst = 1'b1;
        #1;
        check("async_rst_grt", 32'(grt), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_owner", 32'(owner), 32'h0);
        @(posedge Clk);
        #2 Rst = 1'b0;
        tick(1); check("post_reset_m3", 32'(grt), 32'h8);
        req = 4'b0000;
        tick(2);

        // unsampled pulse is ignored, a one-edge pulse earns one grant cycle
        req = 4'b0010;
        #4 req = 4'b0000;
        @(posedge Clk);
        #2;
        check("pulse_ignored", 32'(grt), 32'h0);
        req = 4'b0010;
        tick(1); check("pulse_grant", 32'(grt), 32'h2);
        req = 4'b0000;
        tick(1); check("pulse_turn", 32'(grt), 32'h0);
        tick(1); check("pulse_idle", 32'(grt), 32'h0);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
